// File: rtl/vga_framebuffer_scan_if.sv
// Purpose: bundles the framebuffer input and the registered VGA output bus of vga_framebuffer_scan.
// Latency: none (wires only).
// Backpressure: none; the display side always accepts pixels.
// Signals:
//   framebuffer  1200 cell bits, bit = row*40 + col
//   vga_r/g/b    4-bit colour channels
//   vga_hs/vs    active-low syncs
//   frame_start  one-clock pulse at the tick of pixel (0,0)
//   active       high while the displayed pixel is visible
interface vga_framebuffer_scan_if;
    logic [1199:0] framebuffer;
    logic [3:0]    vga_r;
    logic [3:0]    vga_g;
    logic [3:0]    vga_b;
    logic          vga_hs;
    logic          vga_vs;
    logic          frame_start;
    logic          active;

    // master: framebuffer producer / display sink
    modport master (
        output framebuffer,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, active
    );

    // slave: the scan-out engine
    modport slave (
        input  framebuffer,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, active
    );
endinterface

// File: rtl/vga_framebuffer_scan.sv
// Purpose: scans a 40x30-cell, 16x16-pixel monochrome framebuffer out as 640x480@60 VGA.
// Latency: all outputs lag the h/v counters by one pixel tick (single output register stage).
// Backpressure: none; free-running raster, framebuffer sampled once per frame at v=480, h=0.
// Ports:
//   clock        system clock (50 MHz); pixel tick generated every PIX_DIV clocks
//   reset_n      asynchronous active-low reset, synchronous release
//   vif (slave)  framebuffer in; vga_r/g/b, vga_hs, vga_vs, frame_start, active out
// Optional feature: define VGA_GRID_EN to paint 12'h333 on every cell's first row and column.
// Raster timing fields are parameters so a reduced raster can be built; the defaults give
// 640x480@60. The visible area must stay within 640x480 so the cell index stays below 1200.
module vga_framebuffer_scan #(
    parameter int          PIX_DIV   = 2,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter int          H_VISIBLE = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33
) (
    input  logic                   clock,
    input  logic                   reset_n,
    vga_framebuffer_scan_if.slave  vif
);

    localparam logic [1:0]  DIV_LAST   = 2'(PIX_DIV - 1);
    localparam logic [9:0]  H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0]  H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] CELL_COLS  = 11'd40;
`ifdef VGA_GRID_EN
    localparam logic [11:0] GRID_COLOR = 12'h333;
`endif

    logic [1:0]    div;
    logic          tick;
    logic [9:0]    h;
    logic [9:0]    v;
    logic          h_last;
    logic          v_last;
    logic [1199:0] snapshot;

    logic          visible;
    logic [10:0]   cell_idx;
    logic          cell_on;
    logic [11:0]   pix_rgb;
    logic          hs_next;
    logic          vs_next;

    logic [11:0]   rgb_q;
    logic          hs_q;
    logic          vs_q;
    logic          fs_q;
    logic          act_q;

    // With PIX_DIV=1 DIV_LAST is 0, div never leaves 0 and tick is high every clock.
    assign tick   = (div == DIV_LAST);
    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div <= 2'd0;
        end else if (tick) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (tick) begin
            if (h_last) begin
                h <= 10'd0;
                v <= v_last ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Capture at the first blanking line: the upstream combinational framebuffer may change
    // at any time, but the displayed frame only ever sees this one copy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snapshot <= '0;
        end else if (tick && (h == 10'd0) && (v == V_VIS_END)) begin
            snapshot <= vif.framebuffer;
        end
    end

    always_comb begin
        visible  = (h < H_VIS_END) && (v < V_VIS_END);
        // Forced to 0 outside the visible area so blanking never addresses past the snapshot.
        cell_idx = visible ? (11'(v[8:4]) * CELL_COLS + 11'(h[9:4])) : 11'd0;
        cell_on  = visible && snapshot[cell_idx];
        pix_rgb  = 12'h000;
        if (visible) begin
            pix_rgb = cell_on ? FG_COLOR : BG_COLOR;
`ifdef VGA_GRID_EN
            if ((h[3:0] == 4'd0) || (v[3:0] == 4'd0)) begin
                pix_rgb = GRID_COLOR;
            end
`endif
        end
        hs_next = !((h >= H_SYNC_BEG) && (h < H_SYNC_END));
        vs_next = !((v >= V_SYNC_BEG) && (v < V_SYNC_END));
    end

    // Single output stage: colour, syncs, active and frame_start all describe the same pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
            act_q <= 1'b0;
        end else begin
            fs_q <= tick && (h == 10'd0) && (v == 10'd0);
            if (tick) begin
                rgb_q <= pix_rgb;
                hs_q  <= hs_next;
                vs_q  <= vs_next;
                act_q <= visible;
            end
        end
    end

    assign vif.vga_r       = rgb_q[11:8];
    assign vif.vga_g       = rgb_q[7:4];
    assign vif.vga_b       = rgb_q[3:0];
    assign vif.vga_hs      = hs_q;
    assign vif.vga_vs      = vs_q;
    assign vif.frame_start = fs_q;
    assign vif.active      = act_q;

endmodule

// File: tb/tb_vga_framebuffer_scan.sv
// Purpose: self-checking bench for vga_framebuffer_scan on a reduced raster (2x3 visible cells).
// Latency: expects every output one pixel tick behind the raster position.
// Backpressure: none; raster is free-running.
module tb_vga_framebuffer_scan;

    localparam int PD = 2;
    localparam int HV = 32, HF = 4, HS = 8, HB = 4;
    localparam int VV = 48, VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = HT * VT * PD;
    localparam logic [11:0] FG = 12'hFA5;
    localparam logic [11:0] BG = 12'h012;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic        act;
    } exp_t;

    localparam exp_t RST_EXP = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0, act: 1'b0};

    typedef struct {
        logic [1199:0] fb;
        int            h1, v1;
        logic [11:0]   c1;
        int            h2, v2;
        logic [11:0]   c2;
    } vec_t;

    typedef struct {
        int          frame;
        int          h;
        int          v;
        logic [11:0] rgb;
        bit          hit;
    } probe_t;

    logic          clock;
    logic          reset_n;
    logic [1199:0] fb;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    // bench-side raster model state
    int            k;
    int            ph, pv, frame_m;
    bit            tick_flag;
    logic [1199:0] snap_m;
    exp_t          cur;
    exp_t          sb_q[$];
    probe_t        probe_q[$];

    vga_framebuffer_scan_if vif ();
    assign vif.framebuffer = fb;

    vga_framebuffer_scan #(
        .PIX_DIV(PD), .FG_COLOR(FG), .BG_COLOR(BG),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .vif     (vif)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    function automatic exp_t dut_now();
        return exp_t'({vif.vga_r, vif.vga_g, vif.vga_b, vif.vga_hs, vif.vga_vs,
                       vif.frame_start, vif.active});
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    task automatic check_probes();
        foreach (probe_q[i]) begin
            chk($sformatf("probe_seen f%0d h%0d v%0d", probe_q[i].frame, probe_q[i].h, probe_q[i].v),
                32'(probe_q[i].hit), 32'd1);
        end
        probe_q.delete();
    endtask

    task automatic add_probe(input int f, input int h, input int v, input logic [11:0] c);
        probe_t p;
        p.frame = f; p.h = h; p.v = v; p.rgb = c; p.hit = 1'b0;
        probe_q.push_back(p);
    endtask

    // Waits (at negedges) until the model says the last tick displayed pixel (h,v) of frame f.
    task automatic wait_pix(input int f, input int h, input int v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(negedge clock);
            if (tick_flag && frame_m == f && ph == h && pv == v) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("reach f%0d h%0d v%0d", f, h, v), 32'(ok), 32'd1);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return vif.vga_hs;
            1:       return vif.vga_vs;
            default: return vif.frame_start;
        endcase
    endfunction

    task automatic wait_level(input int sel, input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            @(posedge clock);
            #1;
            if (sig(sel) === lvl) begin
                at = cyc;
                break;
            end
        end
        chk($sformatf("level sel%0d=%0d seen", sel, lvl), 32'(at >= 0), 32'd1);
    endtask

    // Scoreboard: expected output pushed at each clock edge from the raster model,
    // popped and compared against the DUT 1 time unit later.
    initial begin : model
        exp_t e;
        exp_t want;
        int   n;
        int   idx;
        int   hits[$];
        k = 0; ph = 0; pv = 0; frame_m = 0; tick_flag = 1'b0; snap_m = '0; cur = RST_EXP;
        forever begin
            @(posedge clock);
            hits.delete();
            if (!reset_n) begin
                k = 0; ph = 0; pv = 0; frame_m = 0; tick_flag = 1'b0;
                snap_m = '0;
                cur = RST_EXP;
            end else begin
                k++;
                if (k % PD == 0) begin
                    n         = k / PD - 1;
                    ph        = n % HT;
                    pv        = (n / HT) % VT;
                    frame_m   = n / (HT * VT);
                    tick_flag = 1'b1;
                    e.act = (ph < HV) && (pv < VV);
                    e.hs  = !((ph >= HV + HF) && (ph < HV + HF + HS));
                    e.vs  = !((pv >= VV + VF) && (pv < VV + VF + VS));
                    e.fs  = (ph == 0) && (pv == 0);
                    e.rgb = 12'h000;
                    if (e.act) begin
                        idx   = (pv / 16) * 40 + (ph / 16);
                        e.rgb = snap_m[idx] ? FG : BG;
`ifdef VGA_GRID_EN
                        if ((ph % 16 == 0) || (pv % 16 == 0)) e.rgb = 12'h333;
`endif
                    end
                    if (ph == 0 && pv == VV) snap_m = fb;
                    cur = e;
                    foreach (probe_q[i]) begin
                        if (probe_q[i].frame == frame_m && probe_q[i].h == ph && probe_q[i].v == pv)
                            hits.push_back(i);
                    end
                end else begin
                    tick_flag = 1'b0;
                    cur.fs    = 1'b0;
                end
            end
            sb_q.push_back(cur);
            #1;
            want = sb_q.pop_front();
            checks++;
            if (dut_now() !== want) begin
                errs++;
                $display("FAIL pixel t=%0t f%0d h%0d v%0d got=%h want=%h",
                         $time, frame_m, ph, pv, dut_now(), want);
            end
            foreach (hits[j]) begin
                chk($sformatf("probe f%0d h%0d v%0d", probe_q[hits[j]].frame,
                              probe_q[hits[j]].h, probe_q[hits[j]].v),
                    32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(probe_q[hits[j]].rgb));
                probe_q[hits[j]].hit = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #(20 * 60000);
        errs++;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[3];
        int t0, t1, t2;

        tbl[0].fb = '0;  tbl[0].fb[0] = 1'b1;
        tbl[0].h1 = 5;   tbl[0].v1 = 5;  tbl[0].c1 = FG;
        tbl[0].h2 = 20;  tbl[0].v2 = 5;  tbl[0].c2 = BG;
        tbl[1].fb = '0;  tbl[1].fb[40] = 1'b1; tbl[1].fb[81] = 1'b1; tbl[1].fb[1199] = 1'b1;
        tbl[1].h1 = 20;  tbl[1].v1 = 40; tbl[1].c1 = FG;
        tbl[1].h2 = 5;   tbl[1].v2 = 20; tbl[1].c2 = FG;
        tbl[2].fb = '1;
        tbl[2].h1 = 5;   tbl[2].v1 = 5;  tbl[2].c1 = FG;
        tbl[2].h2 = 40;  tbl[2].v2 = 5;  tbl[2].c2 = 12'h000;

        reset_n = 1'b0;
        fb      = '0;
        repeat (3) @(negedge clock);
        chk("reset_state", 32'(dut_now()), 32'(RST_EXP));
        reset_n = 1'b1;
        add_probe(0, 5, 5, BG);

        fork
            begin : timing
                wait_level(0, 1'b0, t0);
                wait_level(0, 1'b1, t1);
                chk("hs_low_clocks", 32'(t1 - t0), 32'(HS * PD));
                wait_level(0, 1'b0, t2);
                chk("line_period", 32'(t2 - t0), 32'(HT * PD));
                wait_level(1, 1'b0, t0);
                chk("vs_first_line", 32'({16'(pv), 16'(ph)}), 32'({16'(VV + VF), 16'd0}));
                wait_level(1, 1'b1, t1);
                chk("vs_low_clocks", 32'(t1 - t0), 32'(VS * HT * PD));
                wait_level(2, 1'b1, t0);
                wait_level(2, 1'b0, t1);
                chk("fs_width", 32'(t1 - t0), 32'd1);
                wait_level(2, 1'b1, t2);
                chk("frame_period", 32'(t2 - t0), 32'(FRAME_CLK));
            end
            begin : stimulus
                for (int i = 0; i < 3; i++) begin
                    wait_pix(i, 0, 0);
                    fb = tbl[i].fb;
                    add_probe(i + 1, tbl[i].h1, tbl[i].v1, tbl[i].c1);
                    add_probe(i + 1, tbl[i].h2, tbl[i].v2, tbl[i].c2);
                end

                // change mid-frame: frame 3 must stay lit, frame 4 goes dark
                wait_pix(3, 0, 20);
                fb = '0;
                add_probe(3, 5, 40, FG);
                add_probe(4, 5, 5, BG);
                add_probe(4, 20, 40, BG);
`ifdef VGA_GRID_EN
                add_probe(4, 16, 5, 12'h333);
                add_probe(4, 5, 32, 12'h333);
`else
                add_probe(4, 16, 5, BG);
                add_probe(4, 5, 32, BG);
`endif

                wait_pix(4, 0, 0);
                fb = '1;
                add_probe(5, 5, 5, FG);

                // reset in the middle of a lit frame
                wait_pix(5, 30, 20);
                chk("pre_reset_rgb", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(FG));
                chk("pre_reset_active", 32'(vif.active), 32'd1);
                check_probes();
                reset_n = 1'b0;
                #1;
                chk("reset_async", 32'(dut_now()), 32'(RST_EXP));
                repeat (3) @(negedge clock);
                reset_n = 1'b1;
                repeat (PD) @(posedge clock);
                #1;
                chk("post_reset_fs", 32'(vif.frame_start), 32'd1);
                chk("post_reset_active", 32'(vif.active), 32'd1);
                chk("post_reset_rgb", 32'({vif.vga_r, vif.vga_g, vif.vga_b}), 32'(BG));
                add_probe(0, 5, 5, BG);
                add_probe(1, 5, 5, FG);
                wait_pix(1, 6, 5);
            end
        join

        repeat (4) @(negedge clock);
        check_probes();
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/vga_framebuffer_scan.md
Name: vga_framebuffer_scan

Overview:
- Downstream stage of the letter-drawing display block: consumes its 1200-bit, 40x30-cell monochrome framebuffer and drives the board's 640x480@60 Hz VGA output.
- Each cell is 16x16 pixels.
- The framebuffer is snapshotted once per frame, at the start of vertical blanking, so the combinational framebuffer never tears mid-frame.
- Generates the pixel-rate enable internally from the 50 MHz system clock.

Parameters:
- PIX_DIV, 2, system clocks per pixel; pixel tick every PIX_DIV cycles; legal values 1..4.
- FG_COLOR, 12'hFFF, {R,G,B} 4:4:4 colour for a set cell.
- BG_COLOR, 12'h000, {R,G,B} colour for a clear cell.

Ports:
- clock  input  1  system clock, 50 MHz
- reset_n  input  1  asynchronous, active-low reset
- framebuffer  input  1200  cell bits; bit index = row*40 + col; row 0 = top, col 0 = left
- vga_r  output  4  red, registered
- vga_g  output  4  green, registered
- vga_b  output  4  blue, registered
- vga_hs  output  1  horizontal sync, active low, registered
- vga_vs  output  1  vertical sync, active low, registered
- frame_start  output  1  one-clock pulse at the pixel tick where h=0, v=0
- active  output  1  high while displayed pixel is in the visible area, aligned with the RGB outputs

Behaviour:
- Reset (async assert, sync release):
  - div counter = 0, h = 0, v = 0, snapshot = 0.
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 1, frame_start = 0, active = 0.
- Pixel tick: div counter counts 0..PIX_DIV-1; tick is asserted when div = PIX_DIV-1. With PIX_DIV=1, tick is asserted every cycle.
- Counters advance on tick only:
  - h counts 0..799, then wraps to 0 and increments v.
  - v counts 0..524, then wraps to 0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751 (hs low), back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491 (vs low), back porch 492..524.
- Cell address: col = h[9:4] (0..39), row = v[8:4] (0..29), index = row*40 + col. Index is computed only when visible; out-of-range h/v never indexes the snapshot.
- Output register, updated on tick:
  - RGB = FG_COLOR if snapshot[index] is set, else BG_COLOR.
  - RGB = 0 outside the visible area.
  - hs, vs and active are registered in the same stage, so all outputs share one pixel tick of latency relative to the counters.
- Snapshot:
  - Loaded from framebuffer on the tick where h=0 and v=480.
  - Held for the whole of the next visible frame.
  - The first frame after reset displays all BG_COLOR.
- frame_start: high for exactly one clock, on the tick cycle with h=0, v=0.
- Outputs hold their value between ticks.
- Reset mid-frame: counters return to 0 immediately; the next frame begins cleanly with the snapshot cleared.

Optional Feature:
- Macro: VGA_GRID_EN.
- When defined: pixels with h[3:0]==0 or v[3:0]==0 inside the visible area output 12'h333, overriding the cell colour, to draw a cell grid for alignment debug.
- When undefined: no grid; cell colours only.

Test Plan:
1. Reset, then run 2 frames with PIX_DIV=2:
   - Expect hs low for 96 ticks (192 clocks) per line.
   - Expect vs low for exactly lines 490..491.
   - Expect line period 1600 clocks and frame period 840000 clocks.
2. framebuffer with only bit 0 set, 2 frames:
   - In frame 2, RGB=FFF exactly for h 0..15, v 0..15 (one tick delayed).
   - All other visible pixels are 000.
   - Frame 1 is entirely 000.
3. framebuffer with only bit 1199 set:
   - FFF only at h 624..639, v 464..479.
   - Nothing lit in the blanking intervals.
4. Toggle framebuffer from all-ones to all-zeros at v=200 of frame N:
   - Frame N remains all FFF.
   - Frame N+1 is all 000 (no tearing).
5. Assert reset_n low at h=300, v=100 for 3 clocks:
   - Outputs go to reset values asynchronously.
   - After release, frame_start pulses at the first tick; h=0 and v=0 are confirmed.
6. Build with VGA_GRID_EN, framebuffer all zero:
   - Pixels at h=16, v=5 and at h=5, v=32 output 333.
   - Pixel at h=5, v=5 outputs 000.
